ghost_dir_gen: RTL and testbench

- Autonomous direction source for one ghost. It emits the direction keycode that the ghost movement block consumes on its randomkeycode input.
- A 16-bit LFSR picks candidate directions. Candidates are screened against the wall flags mapL/R/B/T and the no-reverse rule.
- Each chosen direction is held for a pseudo-random number of frames.
- One instance per ghost. SEED differs per ghost so the ghosts decorrelate.

---
 rtl/ghost_pkg.sv | 43 ++++
 rtl/ghost_lfsr16.sv | 34 +++
 rtl/ghost_dir_gen.sv | 181 ++++++++++++++++++
 tb/tb_ghost_dir_gen.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ghost_pkg.sv
// Shared ghost definitions: direction encoding, keycodes and small helpers.
package ghost_pkg;

  typedef enum logic [1:0] {
    LEFT  = 2'd0,
    RIGHT = 2'd1,
    DOWN  = 2'd2,
    UP    = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPick = 2'd1,
    StHold = 2'd2
  } gen_state_t;

  localparam logic [7:0] KEY_LEFT  = 8'h1A;
  localparam logic [7:0] KEY_RIGHT = 8'h04;
  localparam logic [7:0] KEY_DOWN  = 8'h07;
  localparam logic [7:0] KEY_UP    = 8'h16;
  localparam logic [7:0] KEY_NONE  = 8'h00;

  // Galois feedback mask for the 16-bit direction LFSR
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [7:0] dir2key(dir_t d);
    logic [7:0] key;
    case (d)
      LEFT:    key = KEY_LEFT;
      RIGHT:   key = KEY_RIGHT;
      DOWN:    key = KEY_DOWN;
      UP:      key = KEY_UP;
      default: key = KEY_NONE;
    endcase
    return key;
  endfunction

  // Opposite direction: encodings pair up as LEFT/RIGHT and DOWN/UP
  function automatic dir_t rev(dir_t d);
    return dir_t'(d ^ 2'b01);
  endfunction

endpackage

// File: rtl/ghost_lfsr16.sv
// Free-running 16-bit Galois LFSR with a guard that recovers from the all-zero state.
module ghost_lfsr16 import ghost_pkg::*; #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        frame_clk,
  input  logic        Reset,
  output logic [15:0] state
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Next value: one Galois shift, or reload SEED if the register ever reads zero
  always_comb begin
    lfsr_d = lfsr_q >> 1;
    if (lfsr_q == 16'h0000) begin
      lfsr_d = SEED;
    end else if (lfsr_q[0]) begin
      lfsr_d = (lfsr_q >> 1) ^ LFSR_TAPS;
    end
  end

  // LFSR register, loaded with SEED on reset
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state = lfsr_q;

endmodule

// File: rtl/ghost_dir_gen.sv
// Autonomous ghost direction source: screens LFSR candidates against walls and the
// no-reverse rule, then holds each chosen direction for a pseudo-random number of frames.
module ghost_dir_gen import ghost_pkg::*; #(
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter logic [5:0]  HOLD_MIN  = 6'd16,
  parameter logic [5:0]  HOLD_MASK = 6'h3F
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       pause,
  input  logic [4:0] mapL,
  input  logic [4:0] mapR,
  input  logic [4:0] mapB,
  input  logic [4:0] mapT,
  output logic [7:0] randomkeycode,
  output logic       new_dir
);

  logic [15:0] lfsr;
  logic        lfsr_unused;

  gen_state_t  state_q, state_d;
  dir_t        dir_q, dir_d;
  logic [1:0]  cand_q, cand_d;
  logic        have_dir_q, have_dir_d;
  logic [6:0]  hold_cnt_q, hold_cnt_d;
  logic [1:0]  attempt_q, attempt_d;
  logic [7:0]  key_q, key_d;
  logic        new_dir_q, new_dir_d;

  logic [3:0]  wall;
  logic [1:0]  cand_raw;
  dir_t        cand;
  dir_t        rev_dir;
  logic        cand_ok;
  logic        rev_ok;
  logic        accept;
  dir_t        accept_dir;
  logic [6:0]  hold_load;

  ghost_lfsr16 #(
    .SEED (SEED)
  ) u_lfsr (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .state     (lfsr)
  );

  // Only the candidate and hold-length bits of the LFSR are consumed
  assign lfsr_unused = ^{lfsr[15:14], lfsr[7:2]};

  // Wall flags indexed by direction encoding
  assign wall = {|mapT, |mapB, |mapR, |mapL};

  // First attempt draws from the LFSR; later attempts rotate through the remaining directions
  assign cand_raw  = (attempt_q == 2'd0) ? lfsr[1:0] : cand_q + 2'd1;
  assign cand      = dir_t'(cand_raw);
  assign rev_dir   = rev(dir_q);
  assign cand_ok   = !wall[cand] && (!have_dir_q || (cand != rev_dir));
  assign rev_ok    = have_dir_q && !wall[rev_dir];
  assign hold_load = {1'b0, HOLD_MIN} + {1'b0, lfsr[13:8] & HOLD_MASK};

  // Accept decision for the PICK state: screened candidate, else reverse after the last reject
  always_comb begin
    accept     = 1'b0;
    accept_dir = cand;
    if (cand_ok) begin
      accept = 1'b1;
    end else if ((attempt_q == 2'd3) && rev_ok) begin
      accept     = 1'b1;
      accept_dir = rev_dir;
    end
  end

  // State register
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; pause overrides every transition
  always_comb begin
    state_d = state_q;
    if (pause) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: state_d = StPick;
        StPick: begin
          // Either an accept or the final reject ends the search
          if (accept || (attempt_q == 2'd3)) begin
            state_d = StHold;
          end
        end
        StHold: begin
          if (wall[dir_q] || (hold_cnt_q == 7'd1)) begin
            state_d = StPick;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Output and datapath next values: keycode, direction, hold counter, attempt counter
  always_comb begin
    dir_d      = dir_q;
    cand_d     = cand_q;
    have_dir_d = have_dir_q;
    hold_cnt_d = hold_cnt_q;
    attempt_d  = attempt_q;
    key_d      = key_q;
    new_dir_d  = 1'b0;
    if (pause) begin
      key_d      = KEY_NONE;
      have_dir_d = 1'b0;
      hold_cnt_d = '0;
      attempt_d  = '0;
    end else begin
      case (state_q)
        StIdle: begin
          key_d      = KEY_NONE;
          have_dir_d = 1'b0;
        end
        StPick: begin
          if (accept) begin
            dir_d      = accept_dir;
            key_d      = dir2key(accept_dir);
            have_dir_d = 1'b1;
            new_dir_d  = (dir2key(accept_dir) != key_q);
            hold_cnt_d = hold_load;
            attempt_d  = '0;
          end else if (attempt_q == 2'd3) begin
            // No usable exit: keep the current command and retry after a minimum hold
            hold_cnt_d = {1'b0, HOLD_MIN};
            attempt_d  = '0;
          end else begin
            attempt_d = attempt_q + 2'd1;
            cand_d    = cand_raw;
          end
        end
        StHold: begin
          if (hold_cnt_q != 7'd0) begin
            hold_cnt_d = hold_cnt_q - 7'd1;
          end
        end
        default: begin
          key_d = KEY_NONE;
        end
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      dir_q      <= LEFT;
      cand_q     <= 2'd0;
      have_dir_q <= 1'b0;
      hold_cnt_q <= '0;
      attempt_q  <= '0;
      key_q      <= KEY_NONE;
      new_dir_q  <= 1'b0;
    end else begin
      dir_q      <= dir_d;
      cand_q     <= cand_d;
      have_dir_q <= have_dir_d;
      hold_cnt_q <= hold_cnt_d;
      attempt_q  <= attempt_d;
      key_q      <= key_d;
      new_dir_q  <= new_dir_d;
    end
  end

  assign randomkeycode = key_q;
  assign new_dir       = new_dir_q;

endmodule

// File: tb/tb_ghost_dir_gen.sv
// Directed self-checking bench for ghost_dir_gen.
module tb_ghost_dir_gen;

  localparam logic [15:0] SEED = 16'hACE1;

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic       pause;
  logic [4:0] mapL, mapR, mapB, mapT;
  logic [7:0] randomkeycode;
  logic       new_dir;

  int checks = 0;
  int errors = 0;

  logic [15:0] lfsr_exp;
  logic [7:0]  first_key;
  bit          seen;

  ghost_dir_gen #(
    .SEED      (SEED),
    .HOLD_MIN  (6'd16),
    .HOLD_MASK (6'h3F)
  ) dut (
    .frame_clk     (frame_clk),
    .Reset         (Reset),
    .pause         (pause),
    .mapL          (mapL),
    .mapR          (mapR),
    .mapB          (mapB),
    .mapT          (mapT),
    .randomkeycode (randomkeycode),
    .new_dir       (new_dir)
  );

  always #5 frame_clk = ~frame_clk;

  function automatic logic [15:0] galois(input logic [15:0] s);
    if (s == 16'h0000) return SEED;
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  function automatic logic [7:0] rev_key(input logic [7:0] k);
    case (k)
      8'h1A:   return 8'h04;
      8'h04:   return 8'h1A;
      8'h07:   return 8'h16;
      8'h16:   return 8'h07;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic key_valid(input logic [7:0] k);
    return (k == 8'h1A) || (k == 8'h04) || (k == 8'h07) || (k == 8'h16);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic set_maps(input logic [4:0] l, input logic [4:0] r, input logic [4:0] b,
                          input logic [4:0] t);
    mapL = l;
    mapR = r;
    mapB = b;
    mapT = t;
  endtask

  // Step until the expected keycode shows up or the edge budget runs out
  task automatic wait_key(input logic [7:0] exp, input int bound, input string tag);
    for (int i = 0; i < bound; i++) begin
      step();
      if (randomkeycode == exp) break;
    end
    chk({tag, "_key"}, randomkeycode, exp);
    chk({tag, "_new_dir"}, new_dir, 1'b1);
  endtask

  initial begin
    Reset = 1'b1;
    pause = 1'b1;
    set_maps(5'd0, 5'd0, 5'd0, 5'd0);

    // Reset values
    #23;
    chk("rst_key", randomkeycode, 8'h00);
    chk("rst_new_dir", new_dir, 1'b0);
    chk("rst_lfsr", dut.lfsr, SEED);
    chk("rst_state", dut.state_q, 2'd0);

    // Paused for 10 frames: no commands, LFSR keeps running
    Reset = 1'b0;
    lfsr_exp = SEED;
    for (int i = 0; i < 10; i++) begin
      step();
      lfsr_exp = galois(lfsr_exp);
      chk("pause_key", randomkeycode, 8'h00);
      chk("pause_new_dir", new_dir, 1'b0);
    end
    chk("pause_lfsr", dut.lfsr, lfsr_exp);
    chk("pause_state", dut.state_q, 2'd0);

    // Open field: first keycode at edge 2, then held for at least HOLD_MIN frames
    pause = 1'b0;
    step();
    chk("open_e1_key", randomkeycode, 8'h00);
    step();
    chk("open_e2_valid", key_valid(randomkeycode), 1'b1);
    chk("open_e2_new_dir", new_dir, 1'b1);
    first_key = randomkeycode;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("open_hold_key", randomkeycode, first_key);
      chk("open_hold_new_dir", new_dir, 1'b0);
    end
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (new_dir) begin
        seen = 1'b1;
        break;
      end
    end
    chk("open_change_seen", seen, 1'b1);
    chk("open_change_valid", key_valid(randomkeycode), 1'b1);
    chk("open_change_not_rev", randomkeycode != rev_key(first_key), 1'b1);

    // Only RIGHT open: RIGHT is the only acceptable direction
    pause = 1'b1;
    step();
    chk("pause2_key", randomkeycode, 8'h00);
    set_maps(5'd1, 5'd0, 5'd1, 5'd1);
    pause = 1'b0;
    wait_key(8'h04, 6, "only_right");
    step();
    step();

    // Dead end: wall ahead, only the reverse open -> LEFT at the 5th edge
    set_maps(5'd0, 5'd1, 5'd1, 5'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("dead_wait_key", randomkeycode, 8'h04);
      chk("dead_wait_new_dir", new_dir, 1'b0);
    end
    step();
    chk("dead_rev_key", randomkeycode, 8'h1A);
    chk("dead_rev_new_dir", new_dir, 1'b1);

    // Boxed in: keycode frozen, no pulses; 5-frame retry loop ends in HOLD after edge 20
    set_maps(5'd1, 5'd1, 5'd1, 5'd1);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("boxed_key", randomkeycode, 8'h1A);
      chk("boxed_new_dir", new_dir, 1'b0);
    end
    mapT = 5'd0;
    wait_key(8'h16, 6, "up_open");

    // DOWN, then pause mid-HOLD, then UP after release despite being the reverse
    pause = 1'b1;
    step();
    chk("pause3_key", randomkeycode, 8'h00);
    set_maps(5'd1, 5'd1, 5'd0, 5'd1);
    pause = 1'b0;
    wait_key(8'h07, 6, "only_down");
    step();
    step();
    pause = 1'b1;
    step();
    chk("pause_hold_key", randomkeycode, 8'h00);
    chk("pause_hold_new_dir", new_dir, 1'b0);
    chk("pause_hold_state", dut.state_q, 2'd0);
    set_maps(5'd1, 5'd1, 5'd1, 5'd0);
    pause = 1'b0;
    wait_key(8'h16, 5, "unpause_rev");

    // Asynchronous reset in the middle of PICK
    step();
    mapT = 5'd1;
    step();
    chk("pick_state", dut.state_q, 2'd1);
    #2;
    Reset = 1'b1;
    #1;
    chk("async_key", randomkeycode, 8'h00);
    chk("async_new_dir", new_dir, 1'b0);
    chk("async_state", dut.state_q, 2'd0);
    chk("async_lfsr", dut.lfsr, SEED);
    chk("async_hold_cnt", dut.hold_cnt_q, 7'd0);
    Reset = 1'b0;

    // Zero-locked LFSR recovers to SEED on the next edge
    force dut.u_lfsr.lfsr_q = 16'h0000;
    #1;
    release dut.u_lfsr.lfsr_q;
    step();
    chk("zero_reload", dut.lfsr, SEED);
    step();
    chk("zero_next", dut.lfsr, galois(SEED));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
